// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register: 2-entry skid buffer with registered in_ready and synchronous flush.
// Define PIPE_STAT_EN to add the saturating stall_cnt/drop_cnt statistics counters.
module elastic_pipe_reg #(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 5,
   parameter int STAT_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W*NUM_FIELDS-1:0] out_data,
`ifdef PIPE_STAT_EN
   output logic [STAT_W-1:0]            stall_cnt,
   output logic [STAT_W-1:0]            drop_cnt,
`endif
   output logic [1:0]                   occupancy
);

   localparam int PW = DATA_W * NUM_FIELDS;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            in_ready_q;
   logic [PW-1:0]   main_q, skid_q;
   logic            accept, consume;
   logic            load_main_in, load_skid, promote;

   // Handshake: a beat transfers on a rising edge where valid && ready on that side.
   // Upstream may hold in_valid/in_data until accepted; in_ready is a flop, so it never
   // depends combinationally on out_ready. The main entry always leaves before the skid entry.
   assign accept    = in_valid && in_ready_q;
   assign consume   = out_valid && out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   always_comb begin
      state_d      = state_q;
      load_main_in = 1'b0;
      load_skid    = 1'b0;
      promote      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d      = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = TWO;
                  load_skid = 1'b1;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (consume) begin
                  state_d = ONE;
                  promote = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   // Payload flops are not touched by flush; out_valid qualifies out_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (promote) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

`ifdef PIPE_STAT_EN
   logic [2:0]      drop_inc;
   logic [STAT_W:0] drop_sum;

   // One per flush cycle, plus held entries not leaving downstream, plus a discarded accept.
   assign drop_inc = 3'd1 + {1'b0, state_q} - {2'b00, consume} + {2'b00, accept};
   assign drop_sum = {1'b0, drop_cnt} + (STAT_W+1)'(drop_inc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != {STAT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STAT_W'(1);
         end
         if (flush) begin
            drop_cnt <= drop_sum[STAT_W] ? {STAT_W{1'b1}} : drop_sum[STAT_W-1:0];
         end
      end
   end
`endif

endmodule
